// File: rtl/filtr_sched.sv
// Sequencer for a cascade of notch stages: one sample in, N_STAGES trig/done rounds, one result out.
// Optional FILTR_SCHED_BYPASS_EN adds a per-sample bypass_mask that skips selected stages.
module filtr_sched #(
   parameter int N_STAGES    = 2,
   parameter int DATA_SIZE   = 24,
   parameter int HOLD_CYCLES = 4,
   parameter int TIMEOUT     = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [DATA_SIZE-1:0]            in_data,
   input  logic                            in_valid,
`ifdef FILTR_SCHED_BYPASS_EN
   input  logic [N_STAGES-1:0]             bypass_mask,
`endif
   output logic                            in_ready,
   output logic [DATA_SIZE-1:0]            out_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [DATA_SIZE-1:0]            stage_data_in,
   output logic [N_STAGES-1:0]             stage_trig,
   input  logic [N_STAGES-1:0]             stage_done,
   input  logic [N_STAGES*DATA_SIZE-1:0]   stage_data_out,
   input  logic                            clr_err,
   output logic                            timeout_err,
   output logic [$clog2(N_STAGES):0]       err_stage
);

   // state  | meaning
   // S_IDLE | waiting for a sample (and for the previous result to drain)
   // S_TRIG | one-cycle sample_trig to stage idx (or skip if bypassed)
   // S_WAIT | waiting for stage_done[idx], watchdog running
   // S_HOLD | keep data_in stable while the stage finishes; capture result
   // S_NEXT | advance to next stage or publish the result
   typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT, S_HOLD, S_NEXT} state_t;

   localparam int IW = $clog2(N_STAGES) + 1;
   localparam int TW = $clog2(TIMEOUT);
   localparam int CW = $clog2(HOLD_CYCLES) + 1;

   state_t               state;
   logic [IW-1:0]        idx;
   logic [IW-1:0]        nxt_idx;
   logic [TW-1:0]        timer;
   logic [CW-1:0]        cnt;
   logic [DATA_SIZE-1:0] data_reg;
   logic [DATA_SIZE-1:0] res_reg;
   logic [DATA_SIZE-1:0] sel_data;
   logic                 sel_done;
   logic                 sel_mask;
   logic [N_STAGES-1:0]  trig_onehot;
`ifdef FILTR_SCHED_BYPASS_EN
   logic [N_STAGES-1:0]  mask_reg;
`endif

   assign in_ready      = (state == S_IDLE) && !out_valid;
   assign stage_data_in = data_reg;
   assign nxt_idx       = (state == S_IDLE) ? '0 : idx + IW'(1);

   // Loop-based selects keep idx width independent of N_STAGES.
   always_comb begin
      sel_done    = 1'b0;
      sel_data    = '0;
      sel_mask    = 1'b0;
      trig_onehot = '0;
      for (int k = 0; k < N_STAGES; k++) begin
         if (idx == IW'(k)) begin
            sel_done = stage_done[k];
            sel_data = stage_data_out[k*DATA_SIZE +: DATA_SIZE];
`ifdef FILTR_SCHED_BYPASS_EN
            sel_mask = mask_reg[k];
`endif
         end
`ifdef FILTR_SCHED_BYPASS_EN
         if (nxt_idx == IW'(k))
            trig_onehot[k] = !((state == S_IDLE) ? bypass_mask[k] : mask_reg[k]);
`else
         if (nxt_idx == IW'(k))
            trig_onehot[k] = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= S_IDLE;
         idx         <= '0;
         timer       <= '0;
         cnt         <= '0;
         data_reg    <= '0;
         res_reg     <= '0;
         out_data    <= '0;
         out_valid   <= 1'b0;
         stage_trig  <= '0;
         timeout_err <= 1'b0;
         err_stage   <= '0;
`ifdef FILTR_SCHED_BYPASS_EN
         mask_reg    <= '0;
`endif
      end else begin
         stage_trig <= '0;
         if (clr_err) begin
            timeout_err <= 1'b0;
            err_stage   <= '0;
         end
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  data_reg   <= in_data;
                  idx        <= '0;
                  stage_trig <= trig_onehot;
`ifdef FILTR_SCHED_BYPASS_EN
                  mask_reg   <= bypass_mask;
`endif
                  state      <= S_TRIG;
               end
            end
            S_TRIG: begin
               timer <= '0;
               if (sel_mask) begin
                  res_reg <= data_reg;
                  state   <= S_NEXT;
               end else begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (sel_done) begin
                  cnt   <= '0;
                  state <= S_HOLD;
               end else if (timer == TW'(TIMEOUT-1)) begin
                  // Hung stage: pass its input through and flag it.
                  timeout_err <= 1'b1;
                  err_stage   <= idx;
                  res_reg     <= data_reg;
                  state       <= S_NEXT;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            S_HOLD: begin
               if (cnt == '0)
                  res_reg <= sel_data;
               if (cnt == CW'(HOLD_CYCLES-1))
                  state <= S_NEXT;
               else
                  cnt <= cnt + CW'(1);
            end
            S_NEXT: begin
               data_reg <= res_reg;
               if (idx == IW'(N_STAGES-1)) begin
                  out_data  <= res_reg;
                  out_valid <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  idx        <= idx + IW'(1);
                  stage_trig <= trig_onehot;
                  state      <= S_TRIG;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_filtr_sched.sv
// Bench for filtr_sched: stage models return data_in+1; results checked through a scoreboard queue.
// Latency is counted from the cycle in_valid is presented (accept edge at its end) to the first cycle out_valid is seen.
module tb_filtr_sched;
   localparam int N  = 2;
   localparam int DW = 24;
   localparam int EW = $clog2(N) + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] stage_data_in;
   logic [N-1:0]  stage_trig;
   logic [N-1:0]  stage_done;
   logic [N*DW-1:0] stage_data_out;
   logic          clr_err = 1'b0;
   logic          timeout_err;
   logic [EW-1:0] err_stage;
`ifdef FILTR_SCHED_BYPASS_EN
   logic [N-1:0]  bypass_mask = '0;
`endif

   filtr_sched #(.N_STAGES(N), .DATA_SIZE(DW), .HOLD_CYCLES(4), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
`ifdef FILTR_SCHED_BYPASS_EN
      .bypass_mask(bypass_mask),
`endif
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .stage_data_in(stage_data_in), .stage_trig(stage_trig), .stage_done(stage_done),
      .stage_data_out(stage_data_out), .clr_err(clr_err), .timeout_err(timeout_err),
      .err_stage(err_stage)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Stage models: result = data_in+1 latched at trig; done pulses dly[k] cycles after trig is seen.
   logic [N-1:0]  done_m = '0;
   logic [N-1:0]  spur = '0;
   logic [N-1:0]  done_en = '1;
   int            dly[N] = '{default: 1};
   int            pend[N] = '{default: 0};
   logic [DW-1:0] sdo[N] = '{default: '0};

   assign stage_done = done_m | spur;
   for (genvar g = 0; g < N; g++) begin : g_sdo
      assign stage_data_out[g*DW +: DW] = sdo[g];
   end

   always @(posedge clk) begin
      for (int k = 0; k < N; k++) begin
         done_m[k] <= 1'b0;
         if (stage_trig[k]) begin
            sdo[k] <= stage_data_in + DW'(1);
            if (done_en[k]) begin
               if (dly[k] <= 1) done_m[k] <= 1'b1;
               else pend[k] <= dly[k] - 1;
            end
         end else if (pend[k] > 0) begin
            pend[k] <= pend[k] - 1;
            if (pend[k] == 1) done_m[k] <= 1'b1;
         end
      end
   end

   // Trig monitor: pulse counts per stage; any pulse longer than one cycle or non-one-hot is bad.
   int           trig_cnt[N] = '{default: 0};
   int           trig_bad = 0;
   logic [N-1:0] prev_trig = '0;
   always @(negedge clk) begin
      for (int k = 0; k < N; k++)
         if (stage_trig[k]) begin
            trig_cnt[k]++;
            if (prev_trig[k]) trig_bad++;
         end
      if ($countones(stage_trig) > 1) trig_bad++;
      prev_trig = stage_trig;
   end

   int n_chk = 0;
   int n_pass = 0;
   logic [DW-1:0] sb[$];
   int t0, t1, seen;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
      chk("in_ready_wait", 32'(in_ready), 32'd1);
   endtask

   task automatic pop(input string tag);
      logic [DW-1:0] exp;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
         return;
      end
      exp = sb.pop_front();
      chk({tag, "_data"}, 32'(out_data), 32'(exp));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_valid_clr"}, 32'(out_valid), 32'd0);
      chk({tag, "_ready_after"}, 32'(in_ready), 32'd1);
   endtask

   task automatic run_one(input string tag, input logic [DW-1:0] din, input logic [DW-1:0] exp,
                          input int exp_lat, input int bp);
      int c0, bad;
      logic [DW-1:0] held;
      wait_ready();
      in_data  = din;
      in_valid = 1'b1;
      c0 = cyc;
      sb.push_back(exp);
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 300 && !out_valid; i++) @(negedge clk);
      chk({tag, "_lat"}, 32'(cyc - c0), 32'(exp_lat));
      if (bp > 0) begin
         held = out_data;
         bad = 0;
         repeat (bp) begin
            @(negedge clk);
            if (!out_valid || out_data !== held || in_ready) bad++;
         end
         chk({tag, "_bp_hold"}, 32'(bad), 32'd0);
      end
      pop(tag);
   endtask

   initial begin
      for (int i = 0; i < 50000; i++) @(negedge clk);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_trig", 32'(stage_trig), 32'd0);
      chk("rst_terr", 32'(timeout_err), 32'd0);
      chk("rst_err_stage", 32'(err_stage), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      t0 = trig_cnt[0]; t1 = trig_cnt[1];
      run_one("single", 24'd100, 24'd102, 15, 0);
      chk("single_trig0", 32'(trig_cnt[0] - t0), 32'd1);
      chk("single_trig1", 32'(trig_cnt[1] - t1), 32'd1);
      chk("single_no_err", 32'(timeout_err), 32'd0);

      run_one("neg", 24'hFFFFFB, 24'hFFFFFD, 15, 0);
      run_one("maxpos", 24'h7FFFFF, 24'h800001, 15, 0);
      run_one("wrap", 24'hFFFFFF, 24'h000001, 15, 0);
      run_one("bp", 24'h123456, 24'h123458, 15, 20);

      // Stage 1 hangs: 16 WAIT cycles, then stage 0's result passes through.
      done_en[1] = 1'b0;
      t1 = trig_cnt[1];
      run_one("tmo", 24'd500, 24'd501, 26, 0);
      done_en[1] = 1'b1;
      chk("tmo_trig1", 32'(trig_cnt[1] - t1), 32'd1);
      chk("tmo_err", 32'(timeout_err), 32'd1);
      chk("tmo_err_stage", 32'(err_stage), 32'd1);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk("clr_err", 32'(timeout_err), 32'd0);
      chk("clr_err_stage", 32'(err_stage), 32'd0);

      // Spurious done[1] while stage 0 (slowed to dly 3) is pending.
      dly[0] = 3;
      fork
         run_one("spur", 24'd42, 24'd44, 17, 0);
         begin
            spur[1] = 1'b1;
            repeat (7) @(negedge clk);
            spur[1] = 1'b0;
         end
      join
      dly[0] = 1;

      // Reset while stage 0 is in HOLD: sample dropped, nothing emitted.
      wait_ready();
      in_data = 24'd7;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_trig", 32'(stage_trig), 32'd0);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      reset = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("mid_rst_no_out", 32'(seen), 32'd0);

      run_one("after_rst", 24'd1000, 24'd1002, 15, 0);

`ifdef FILTR_SCHED_BYPASS_EN
      bypass_mask = 2'b01;
      t0 = trig_cnt[0]; t1 = trig_cnt[1];
      run_one("byp", 24'd50, 24'd51, 10, 0);
      bypass_mask = 2'b00;
      chk("byp_trig0", 32'(trig_cnt[0] - t0), 32'd0);
      chk("byp_trig1", 32'(trig_cnt[1] - t1), 32'd1);
`endif

      chk("trig_width", 32'(trig_bad), 32'd0);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
